pairing_host_ctrl: RTL and testbench

Host-side controller for the BN254 pairing core. It takes one command from the host and runs it in four steps: load operands into the core RAMs, pulse `run` with the selected function, wait for `endflag`, then stream results back out. It sits between a valid/ready host port and the core's `extin_*`/`extout_*`/`run`/`busy`/`endflag` pins, and is the only master of those pins.

---
 rtl/PARAMS_BN254_d0.sv | 8 +
 rtl/pairing_host_ctrl_pkg.sv | 22 ++
 rtl/pairing_host_ctrl_rd_fifo.sv | 55 +++++
 rtl/pairing_host_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pairing_host_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/PARAMS_BN254_d0.sv
// Shared BN254 core parameters: the word type carried on the core RAM ports.
package PARAMS_BN254_d0;

   localparam int POLY_W = 264;

   typedef logic [POLY_W-1:0] redundant_poly_L3;

endpackage

// File: rtl/pairing_host_ctrl_pkg.sv
// Host-controller types and sizing shared by the controller and its read FIFO.
package HOST_CTRL;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT,
      DRAIN,
      ABORT
   } host_state_t;

   localparam int RD_LAT_DEF = 2;

   // Depth of RD_LAT + 2 keeps a full-rate drain bubble-free.
   function automatic int fifo_depth(input int rd_lat);
      return rd_lat + 2;
   endfunction

   localparam int FIFO_DEPTH = fifo_depth(RD_LAT_DEF);

endpackage

// File: rtl/pairing_host_ctrl_rd_fifo.sv
// Small synchronous FIFO that buffers core read data ahead of the host result port.
module pairing_rd_fifo
   import PARAMS_BN254_d0::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             push_i,
   input  redundant_poly_L3 din_i,
   input  logic             pop_i,
   output redundant_poly_L3 dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   redundant_poly_L3 mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // A push is still accepted when full as long as a pop frees a slot the same cycle.
   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/pairing_host_ctrl.sv
// Host-side sequencer for the BN254 pairing core: load operands, start, wait, drain results.
module pairing_host_ctrl
   import PARAMS_BN254_d0::*;
   import HOST_CTRL::*;
#(
   parameter logic [8:0]  IN_BASE  = 9'd0,
   parameter int          N_IN     = 12,
   parameter logic [8:0]  OUT_BASE = 9'd256,
   parameter int          N_OUT    = 12,
   parameter int          RD_LAT   = 2,
   parameter logic [23:0] TIMEOUT  = 24'hFF_FFFF
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_func,
   input  logic             in_valid,
   output logic             in_ready,
   input  redundant_poly_L3 in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output redundant_poly_L3 out_data,
   output logic             out_last,
   output logic             err_timeout,
   output logic             extin_en,
   output logic [8:0]       extin_addr,
   output redundant_poly_L3 extin_data,
   output logic [8:0]       extout_addr,
   input  redundant_poly_L3 extout_data,
   output logic             run,
   output logic             swrst,
   output logic [3:0]       n_func,
   input  logic             busy,
   input  logic             endflag
);

   localparam int              FIFO_D   = fifo_depth(RD_LAT);
   localparam int              FCW      = $clog2(FIFO_D + 1);
   localparam int              IW       = FCW + 1;
   localparam int              CW       = 10;
   localparam logic [CW-1:0]   LAST_IN  = CW'(N_IN - 1);
   localparam logic [CW-1:0]   LAST_OUT = CW'(N_OUT - 1);
   localparam logic [CW-1:0]   N_OUT_C  = CW'(N_OUT);

   if (int'(IN_BASE) + N_IN > 512) begin : g_in_range
      $error("IN_BASE + N_IN runs past the 512-word core RAM");
   end
   if (int'(OUT_BASE) + N_OUT > 512) begin : g_out_range
      $error("OUT_BASE + N_OUT runs past the 512-word core RAM");
   end
   if (RD_LAT < 1) begin : g_rd_lat
      $error("RD_LAT must be at least one cycle");
   end
   if (TIMEOUT == 24'd0) begin : g_timeout
      $error("TIMEOUT must be non-zero");
   end

   host_state_t      state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
   logic [CW-1:0]    pop_cnt_q, pop_cnt_d;
   logic [23:0]      tmo_q, tmo_d;
   logic [3:0]       func_q, func_d;
   logic             err_q, err_d;
   logic [RD_LAT-1:0] vld_q;

   logic             cmd_hs, in_hs, rd_issue, pop, push;
   logic [IW-1:0]    inflight;
   logic [FCW-1:0]   fifo_cnt;
   logic             fifo_full, fifo_empty;
   redundant_poly_L3 fifo_head;

   assign cmd_ready = rstn && (state_q == IDLE) && !busy;
   assign cmd_hs    = cmd_valid && cmd_ready;
   assign in_ready  = (state_q == LOAD);
   assign in_hs     = in_valid && in_ready;

   // Operand writes go straight to the core RAM in the handshake cycle.
   assign extin_en   = in_hs;
   assign extin_addr = IN_BASE + cnt_q[8:0];
   assign extin_data = in_hs ? in_data : '0;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) inflight = inflight + IW'(vld_q[i]);
   end

   // Credit check: reads in flight plus stored words may never exceed the FIFO depth.
   assign rd_issue    = (state_q == DRAIN) && (rd_cnt_q < N_OUT_C) &&
                        ((inflight + IW'(fifo_cnt)) < IW'(FIFO_D));
   assign extout_addr = (state_q == DRAIN) ? OUT_BASE + rd_cnt_q[8:0] : OUT_BASE;
   assign push        = vld_q[RD_LAT-1];

   assign out_valid   = (state_q == DRAIN) && !fifo_empty;
   assign pop         = out_valid && out_ready;
   assign out_data    = out_valid ? fifo_head : '0;
   assign out_last    = out_valid && (pop_cnt_q == LAST_OUT);

   assign run         = (state_q == START);
   assign swrst       = (state_q == ABORT);
   assign n_func      = func_q;
   assign err_timeout = err_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_cnt_d  = rd_cnt_q;
      pop_cnt_d = pop_cnt_q;
      tmo_d     = tmo_q;
      func_d    = func_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (cmd_hs) begin
               func_d  = cmd_func;
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = (N_IN == 0) ? START : LOAD;
            end
         end
         LOAD: begin
            if (in_hs) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST_IN) state_d = START;
            end
         end
         START: begin
            tmo_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            tmo_d = tmo_q + 24'd1;
            // Completion takes priority over a timeout landing in the same cycle.
            if (endflag) begin
               rd_cnt_d  = '0;
               pop_cnt_d = '0;
               state_d   = (N_OUT == 0) ? IDLE : DRAIN;
            end else if (tmo_d == TIMEOUT) begin
               err_d   = 1'b1;
               state_d = ABORT;
            end
         end
         DRAIN: begin
            if (rd_issue) rd_cnt_d = rd_cnt_q + CW'(1);
            if (pop) begin
               pop_cnt_d = pop_cnt_q + CW'(1);
               if (pop_cnt_q == LAST_OUT) state_d = IDLE;
            end
         end
         ABORT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rd_cnt_q  <= '0;
         pop_cnt_q <= '0;
         tmo_q     <= '0;
         func_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         pop_cnt_q <= pop_cnt_d;
         tmo_q     <= tmo_d;
         func_q    <= func_d;
         err_q     <= err_d;
      end
   end

   // Read-valid tag follows the RAM latency; its exit registers the data into the FIFO.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= rd_issue;
         for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
      end
   end

   pairing_rd_fifo #(
      .DEPTH (FIFO_D),
      .CNT_W (FCW)
   ) u_fifo (
      .clk_i   (clk),
      .rstn_i  (rstn),
      .push_i  (push),
      .din_i   (extout_data),
      .pop_i   (pop),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
      !(push && fifo_full && !pop));

endmodule

// File: tb/tb_pairing_host_ctrl.sv
// Scoreboard bench for pairing_host_ctrl with a small pairing-core model behind it.
module tb_pairing_host_ctrl;
   import PARAMS_BN254_d0::*;

   localparam int          NW     = 12;
   localparam int          RD_LAT = 2;
   localparam logic [23:0] TMO    = 24'd50;

   logic             clk = 1'b0;
   logic             rstn;
   logic             cmd_valid, cmd_ready;
   logic [3:0]       cmd_func;
   logic             in_valid, in_ready;
   redundant_poly_L3 in_data;
   logic             out_valid, out_ready;
   redundant_poly_L3 out_data;
   logic             out_last, err_timeout;
   logic             extin_en;
   logic [8:0]       extin_addr, extout_addr;
   redundant_poly_L3 extin_data, extout_data;
   logic             run, swrst;
   logic [3:0]       n_func;
   logic             busy, endflag;

   always #5 clk = ~clk;

   pairing_host_ctrl #(
      .IN_BASE (9'd0), .N_IN (NW), .OUT_BASE (9'd256), .N_OUT (NW),
      .RD_LAT (RD_LAT), .TIMEOUT (TMO)
   ) dut (
      .clk (clk), .rstn (rstn),
      .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_func (cmd_func),
      .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
      .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
      .out_last (out_last), .err_timeout (err_timeout),
      .extin_en (extin_en), .extin_addr (extin_addr), .extin_data (extin_data),
      .extout_addr (extout_addr), .extout_data (extout_data),
      .run (run), .swrst (swrst), .n_func (n_func),
      .busy (busy), .endflag (endflag)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [299:0] act, input logic [299:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   function automatic redundant_poly_L3 op_word(input logic [7:0] tag, input int i);
      redundant_poly_L3 w;
      w = '0;
      w[263:256] = tag;
      w[207:200] = 8'hA5 ^ 8'(i);
      w[7:0]     = 8'(i);
      return w;
   endfunction

   function automatic redundant_poly_L3 res_word(input logic [7:0] tag, input logic [8:0] a);
      redundant_poly_L3 w;
      w = '0;
      w[263:256] = ~tag;
      w[135:128] = tag;
      w[8:0]     = a;
      return w;
   endfunction

   // Core model: result RAM contents depend on the address, read through RD_LAT registers.
   logic [7:0] cur_tag = 8'h00;
   logic [8:0] ra_p1 = '0, ra_p2 = '0;
   always @(posedge clk) begin
      ra_p1 <= extout_addr;
      ra_p2 <= ra_p1;
   end
   assign extout_data = res_word(cur_tag, ra_p2);

   int end_dly = 20;
   initial begin
      endflag = 1'b0;
      forever begin
         @(negedge clk);
         if (run && rstn && end_dly >= 0) begin
            repeat (end_dly) @(posedge clk);
            #1 endflag = 1'b1;
            @(posedge clk);
            #1 endflag = 1'b0;
         end
      end
   end

   logic       bp_mode = 1'b0;
   logic [3:0] bp_pat  = 4'b1001;
   int         pc      = 0;
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bp_mode) begin
            out_ready = bp_pat[pc];
            pc = (pc + 1) % 4;
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   typedef struct packed { logic [8:0] addr; redundant_poly_L3 data; } wr_t;
   typedef struct packed { redundant_poly_L3 data; logic last; } out_t;
   typedef struct packed { logic [3:0] func; int cyc; } run_t;

   wr_t  wr_q[$];
   out_t out_q[$];
   run_t run_q[$];
   wr_t  wexp;
   out_t oexp;
   run_t rexp;

   int cyc = 0;
   int n_wr = 0, n_out = 0, n_run = 0, n_swrst = 0;
   int first_ov = -1, end_cyc = -1, swrst_cyc = -1, last_run_cyc = -1;
   int max_occ = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rstn) begin
         if (extin_en) begin
            if (wr_q.size() == 0) chk("extin_en unexpected", extin_en, 1'b0);
            else begin
               wexp = wr_q.pop_front();
               chk("extin_addr", extin_addr, wexp.addr);
               chk("extin_data", extin_data, wexp.data);
            end
            n_wr++;
         end
         if (out_valid && first_ov < 0) first_ov = cyc;
         if (out_valid && out_ready) begin
            if (out_q.size() == 0) chk("out_valid unexpected", out_valid, 1'b0);
            else begin
               oexp = out_q.pop_front();
               chk("out_data", out_data, oexp.data);
               chk("out_last", out_last, oexp.last);
            end
            n_out++;
         end
         if (run) begin
            if (run_q.size() == 0) chk("run unexpected", run, 1'b0);
            else begin
               rexp = run_q.pop_front();
               chk("n_func at run", n_func, rexp.func);
               chk("run cycle", cyc, rexp.cyc);
            end
            last_run_cyc = cyc;
            n_run++;
         end
         if (swrst) begin
            n_swrst++;
            swrst_cyc = cyc;
         end
         if (endflag) end_cyc = cyc;
         if (int'(dut.u_fifo.count_o) > max_occ) max_occ = int'(dut.u_fifo.count_o);
      end
   end

   task automatic do_cmd(input logic [3:0] func, input logic [7:0] tag, input bit expect_out);
      int k;
      cur_tag  = tag;
      first_ov = -1;
      if (expect_out)
         for (int i = 0; i < NW; i++)
            out_q.push_back('{data: res_word(tag, 9'(256 + i)), last: (i == NW - 1)});
      cmd_func  = func;
      cmd_valid = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!cmd_ready && k < 100);
      chk("cmd accepted", cmd_ready, 1'b1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_func  = 4'hF;
      chk("LOAD one cycle after cmd", in_ready, 1'b1);
      chk("err_timeout cleared by cmd", err_timeout, 1'b0);
      for (int i = 0; i < NW; i++) begin
         in_valid = 1'b1;
         in_data  = op_word(tag, i);
         wr_q.push_back('{addr: 9'(i), data: op_word(tag, i)});
         if (i == NW - 1) run_q.push_back('{func: func, cyc: cyc + 1});
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic wait_drain(input string nm);
      for (int k = 0; k < 600 && out_q.size() != 0; k++) @(posedge clk);
      chk({nm, " words left undelivered"}, out_q.size(), 0);
      @(posedge clk);
      #1;
      chk({nm, " back in IDLE"}, cmd_ready, 1'b1);
   endtask

   int sw0, o0, r0, w0;

   initial begin
      rstn = 1'b0; busy = 1'b0;
      cmd_valid = 1'b0; cmd_func = 4'h0;
      in_valid = 1'b0; in_data = '0;
      #1;
      chk("reset cmd_ready", cmd_ready, 1'b0);
      chk("reset run/swrst/extin_en", {run, swrst, extin_en}, 3'b000);
      chk("reset in_ready/out_valid/out_last", {in_ready, out_valid, out_last}, 3'b000);
      chk("reset err_timeout/n_func", {err_timeout, n_func}, 5'h00);
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      #1;
      chk("idle cmd_ready", cmd_ready, 1'b1);
      chk("idle extout_addr", extout_addr, 9'd256);

      // Full command at full output rate.
      end_dly = 20;
      do_cmd(4'h3, 8'h11, 1'b1);
      wait_drain("full");
      chk("full first out_valid latency", first_ov, end_cyc + 4);
      chk("full run count", n_run, 1);
      chk("full write count", n_wr, NW);

      // Drain with output backpressure 1,0,0,1.
      max_occ = 0;
      bp_mode = 1'b1;
      do_cmd(4'h5, 8'h22, 1'b1);
      wait_drain("bp");
      bp_mode = 1'b0;
      chk("bp fifo peak within depth", max_occ <= 4, 1'b1);
      chk("bp output count", n_out, 2 * NW);

      // Timeout with endflag never arriving.
      end_dly = -1;
      sw0 = n_swrst; o0 = n_out;
      do_cmd(4'h7, 8'h33, 1'b0);
      for (int k = 0; k < 200 && n_swrst == sw0; k++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      chk("timeout swrst pulse width", n_swrst - sw0, 1);
      chk("timeout swrst cycle", swrst_cyc, last_run_cyc + 51);
      chk("timeout err_timeout", err_timeout, 1'b1);
      chk("timeout back in IDLE", cmd_ready, 1'b1);
      chk("timeout no results", n_out - o0, 0);

      // endflag on the exact timeout cycle.
      end_dly = 50;
      sw0 = n_swrst;
      do_cmd(4'h9, 8'h44, 1'b1);
      wait_drain("tie");
      chk("tie endflag cycle", end_cyc, last_run_cyc + 50);
      chk("tie no swrst", n_swrst - sw0, 0);
      chk("tie err_timeout", err_timeout, 1'b0);

      // Host traffic that must be ignored.
      end_dly = 20;
      r0 = n_run;
      busy = 1'b1;
      cmd_valid = 1'b1;
      cmd_func  = 4'hA;
      repeat (5) @(posedge clk);
      #1;
      chk("busy blocks cmd_ready", cmd_ready, 1'b0);
      cmd_valid = 1'b0;
      busy = 1'b0;
      chk("busy no run", n_run - r0, 0);
      do_cmd(4'hB, 8'h55, 1'b1);
      cmd_valid = 1'b1;
      cmd_func  = 4'hC;
      repeat (10) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk("cmd during WAIT not latched", n_func, 4'hB);
      for (int k = 0; k < 100 && !out_valid; k++) @(posedge clk);
      w0 = n_wr;
      in_valid = 1'b1;
      in_data  = op_word(8'hEE, 0);
      wait_drain("ignore");
      in_valid = 1'b0;
      chk("in_valid in DRAIN no writes", n_wr - w0, 0);
      chk("single run for command", n_run - r0, 1);

      // Asynchronous reset in the middle of a drain.
      o0 = n_out;
      do_cmd(4'h2, 8'h66, 1'b1);
      for (int k = 0; k < 300 && (n_out - o0) < 5; k++) begin
         @(posedge clk);
         #2;
      end
      chk("reset-test outputs before reset", n_out - o0, 5);
      rstn = 1'b0;
      #1;
      chk("async reset control outputs",
          {run, swrst, extin_en, in_ready, out_valid, out_last, cmd_ready, err_timeout}, 8'h00);
      chk("async reset n_func", n_func, 4'h0);
      out_q.delete();
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      #1;
      chk("after reset cmd_ready", cmd_ready, 1'b1);
      chk("after reset fifo empty", dut.u_fifo.empty_o, 1'b1);
      o0 = n_out;
      repeat (10) @(posedge clk);
      #1;
      chk("after reset no outputs", n_out - o0, 0);
      chk("after reset no swrst", swrst, 1'b0);

      chk("pending writes", wr_q.size(), 0);
      chk("pending runs", run_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog");
   end

endmodule
